// File: rtl/nec_pkg.sv
// Shared encodings for the pet need controller: FSM states, need indices and level limits.
package nec_pkg;

  typedef enum logic [1:0] {
    DESPIERTO = 2'd0,
    ANIMANDO  = 2'd1,
    DORMIDO   = 2'd2,
    MUERTO    = 2'd3
  } estado_t;

  localparam int NEC_HAMBRE    = 0;
  localparam int NEC_SUENO     = 1;
  localparam int NEC_DIVERSION = 2;
  localparam int NEC_SALUD     = 3;

  localparam logic [1:0] NIVEL_MAX = 2'd3;
  localparam logic [1:0] NIVEL_MIN = 2'd0;

endpackage

// File: rtl/base_tiempo.sv
// Base time tick generator: one-cycle pulse every TICK_DIV cycles, or every TICK_DIV/TEST_DIV
// cycles in test mode. A change of modo_test restarts the count from zero.
module base_tiempo #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TEST_DIV = 1000
) (
  input  logic clk,
  input  logic B_reset,
  input  logic modo_test,
  output logic tick
);

  localparam int DIV_TEST = (TICK_DIV / TEST_DIV > 0) ? TICK_DIV / TEST_DIV : 1;
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] FIN_NORMAL = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] FIN_TEST   = CW'(DIV_TEST - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] fin;
  logic          modo_q;
  logic          cambio;

  assign fin    = modo_test ? FIN_TEST : FIN_NORMAL;
  assign cambio = modo_test ^ modo_q;
  // The cycle in which the mode changes never ticks; counting restarts cleanly from zero.
  assign tick   = !cambio && (cnt == fin);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge B_reset) begin
    if (B_reset) begin
      cnt    <= '0;
      modo_q <= 1'b0;
    end else begin
      modo_q <= modo_test;
      if (cambio || tick) cnt <= '0;
      else                cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/controlador_necesidades.sv
// Need-meter sequencer: round-robin meter enables on each base tick, user actions as level-up
// toggles, and the awake/animating/sleeping/dead FSM with lowest-need and alert reporting.
module controlador_necesidades
  import nec_pkg::*;
#(
  parameter int NUM_NEC     = 4,
  parameter int TICK_DIV    = 50_000_000,
  parameter int TEST_DIV    = 1000,
  parameter int SUENO_TICKS = 4,
  parameter int GUARDA      = 3,
  parameter int MUERTE_UMB  = 2
) (
  input  logic                       clk,
  input  logic                       B_reset,
  input  logic                       modo_test,
  input  logic [NUM_NEC-1:0]         boton,
  input  logic [2*NUM_NEC-1:0]       niveles,
  input  logic [NUM_NEC-1:0]         senal_5seg,
  output logic [NUM_NEC-1:0]         activo,
  output logic [NUM_NEC-1:0]         entrada,
  output logic [1:0]                 estado,
  output logic [$clog2(NUM_NEC)-1:0] critica,
  output logic                       alerta
);

  localparam int PW = $clog2(NUM_NEC);
  localparam int SW = (SUENO_TICKS > 1) ? $clog2(SUENO_TICKS) : 1;
  localparam int GW = $clog2(GUARDA + 1) > 0 ? $clog2(GUARDA + 1) : 1;

  localparam logic [PW-1:0] PTR_ULT   = PW'(NUM_NEC - 1);
  localparam logic [PW-1:0] SUENO_IDX = PW'(NEC_SUENO);
  localparam logic [SW-1:0] SUENO_ULT = SW'(SUENO_TICKS - 1);
  localparam logic [GW-1:0] GUARDA_L  = GW'(GUARDA);

  estado_t       est, est_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [SW-1:0] sueno_cnt, sueno_cnt_n;
  logic [GW-1:0] guarda_cnt, guarda_cnt_n;
  logic [NUM_NEC-1:0] activo_n, entrada_n;

  logic          tick;
  logic          hay_boton;
  logic [PW-1:0] sel;
  logic [PW-1:0] min_idx;
  logic [1:0]    min_val;
  logic [1:0]    lvl;
  int unsigned   ceros;
  logic          muerte;

  base_tiempo #(
    .TICK_DIV (TICK_DIV),
    .TEST_DIV (TEST_DIV)
  ) u_base_tiempo (
    .clk       (clk),
    .B_reset   (B_reset),
    .modo_test (modo_test),
    .tick      (tick)
  );

  // Lowest-level finder (strict < keeps the lowest index on ties) and zero-level count.
  always_comb begin
    min_idx = '0;
    min_val = niveles[1:0];
    ceros   = 0;
    lvl     = '0;
    for (int i = 0; i < NUM_NEC; i++) begin
      lvl = niveles[2*i +: 2];
      if (lvl == NIVEL_MIN) ceros = ceros + 1;
      if (lvl < min_val) begin
        min_val = lvl;
        min_idx = PW'(i);
      end
    end
  end

  assign muerte = (ceros >= MUERTE_UMB);

  // Lowest set button bit wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_NEC - 1; i >= 0; i--) begin
      if (boton[i]) sel = PW'(i);
    end
  end

  assign hay_boton = |boton;

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    est_n        = est;
    ptr_n        = ptr;
    activo_n     = '0;
    entrada_n    = entrada;
    guarda_cnt_n = guarda_cnt;
    sueno_cnt_n  = sueno_cnt;

    if (muerte) begin
      est_n = MUERTO;
    end else begin
      unique case (est)
        DESPIERTO, ANIMANDO: begin
          if (tick) begin
            activo_n = NUM_NEC'(1) << ptr;
            ptr_n    = (ptr == PTR_ULT) ? '0 : ptr + PW'(1);
          end
          if (est == DESPIERTO) begin
            if (hay_boton) begin
              if (sel == SUENO_IDX) begin
                est_n       = DORMIDO;
                sueno_cnt_n = '0;
              end else begin
                entrada_n[sel] = ~entrada[sel];
                guarda_cnt_n   = '0;
                est_n          = ANIMANDO;
              end
            end
          end else begin
            // Guard covers the meter's latency in raising its flag; it holds at GUARDA.
            if (guarda_cnt < GUARDA_L) guarda_cnt_n = guarda_cnt + GW'(1);
            else if (senal_5seg == '0) est_n = DESPIERTO;
          end
        end
        DORMIDO: begin
          if (niveles[2*NEC_SUENO +: 2] == NIVEL_MAX || hay_boton) begin
            est_n = DESPIERTO;
          end else if (tick) begin
            if (sueno_cnt == SUENO_ULT) begin
              sueno_cnt_n          = '0;
              entrada_n[NEC_SUENO] = ~entrada[NEC_SUENO];
              activo_n[NEC_SUENO]  = 1'b1;
            end else begin
              sueno_cnt_n = sueno_cnt + SW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge B_reset) begin
    if (B_reset) begin
      est        <= DESPIERTO;
      ptr        <= '0;
      activo     <= '0;
      entrada    <= '0;
      guarda_cnt <= '0;
      sueno_cnt  <= '0;
      critica    <= '0;
      alerta     <= 1'b0;
    end else begin
      est        <= est_n;
      ptr        <= ptr_n;
      activo     <= activo_n;
      entrada    <= entrada_n;
      guarda_cnt <= guarda_cnt_n;
      sueno_cnt  <= sueno_cnt_n;
      critica    <= min_idx;
      alerta     <= (ceros != 0);
    end
  end

  assign estado = est;

endmodule
